// File: rtl/vote_argmax_if.sv
// Count stream in, per-frame arg-max result out.
// The DUT side uses slave; the count source and result consumer use master.
interface vote_argmax_if #(
  parameter int NUM_CLASS = 3,
  parameter int COUNT_BIT = 3
);
  localparam int CLASS_BIT = $clog2(NUM_CLASS);

  logic [COUNT_BIT-1:0] cnt_in;
  logic                 cnt_vld;
  logic [CLASS_BIT-1:0] class_out;
  logic [COUNT_BIT-1:0] max_out;
  logic                 tie_out;
  logic                 out_vld;

  modport master (
    output cnt_in, cnt_vld,
    input  class_out, max_out, tie_out, out_vld
  );

  modport slave (
    input  cnt_in, cnt_vld,
    output class_out, max_out, tie_out, out_vld
  );
endinterface

// File: rtl/vote_argmax.sv
// Sequential arg-max over per-class vote counts.
// Emits the winning class, its count and a tie flag per frame.
module vote_argmax #(
  parameter int NUM_CLASS = 3,
  parameter int COUNT_BIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  vote_argmax_if.slave  bus
);
  localparam int CLASS_BIT = $clog2(NUM_CLASS);
  localparam logic [CLASS_BIT-1:0] LAST = CLASS_BIT'(NUM_CLASS - 1);

  logic [CLASS_BIT-1:0] idx;
  logic [COUNT_BIT-1:0] cur_max;
  logic [CLASS_BIT-1:0] cur_cls;
  logic                 cur_tie;

  logic [COUNT_BIT-1:0] nxt_max;
  logic [CLASS_BIT-1:0] nxt_cls;
  logic                 nxt_tie;

  logic first;
  logic last;
  logic gt;
  logic eq;

  assign first = (idx == '0);
  assign last  = (idx == LAST);
  assign gt    = (bus.cnt_in > cur_max);
  assign eq    = (bus.cnt_in == cur_max);

  // Strict > keeps the lowest index on equal maxima.
  always_comb begin
    nxt_max = cur_max;
    nxt_cls = cur_cls;
    nxt_tie = cur_tie;
    unique case (1'b1)
      first: begin
        nxt_max = bus.cnt_in;
        nxt_cls = '0;
        nxt_tie = 1'b0;
      end
      (!first && gt): begin
        nxt_max = bus.cnt_in;
        nxt_cls = idx;
        nxt_tie = 1'b0;
      end
      (!first && eq): begin
        nxt_tie = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      cur_max       <= '0;
      cur_cls       <= '0;
      cur_tie       <= 1'b0;
      bus.class_out <= '0;
      bus.max_out   <= '0;
      bus.tie_out   <= 1'b0;
      bus.out_vld   <= 1'b0;
    end else begin
      bus.out_vld <= 1'b0;
      if (bus.cnt_vld) begin
        idx     <= last ? '0 : idx + CLASS_BIT'(1);
        cur_max <= nxt_max;
        cur_cls <= nxt_cls;
        cur_tie <= nxt_tie;
        if (last) begin
          bus.class_out <= nxt_cls;
          bus.max_out   <= nxt_max;
          bus.tie_out   <= nxt_tie;
          bus.out_vld   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vote_argmax.sv
// Self-checking bench for vote_argmax: directed frames plus
// random stream against a per-frame arg-max reference model.
module tb_vote_argmax;
  localparam int NUM_CLASS = 3;
  localparam int COUNT_BIT = 3;

  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;

  vote_argmax_if #(.NUM_CLASS(NUM_CLASS), .COUNT_BIT(COUNT_BIT)) b ();

  vote_argmax #(.NUM_CLASS(NUM_CLASS), .COUNT_BIT(COUNT_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  always #5 clk = ~clk;

  // {out_vld, class_out, max_out, tie_out}
  wire [6:0] obs = {b.out_vld, b.class_out, b.max_out, b.tie_out};

  // Reference model: collect a frame, then take its arg-max.
  int       q[$];
  logic     e_vld;
  logic [1:0] e_cls;
  logic [2:0] e_max;
  logic     e_tie;

  task automatic cyc(input logic v, input int c, input logic r);
    int best;
    int n;
    b.cnt_vld = v;
    b.cnt_in  = 3'(c);
    rst       = r;
    @(posedge clk);
    #1;
    e_vld = 1'b0;
    if (r) begin
      q.delete();
      e_cls = '0;
      e_max = '0;
      e_tie = 1'b0;
    end else if (v) begin
      q.push_back(c);
      if (q.size() == NUM_CLASS) begin
        best = 0;
        n    = 0;
        for (int i = 0; i < NUM_CLASS; i++)
          if (q[i] > q[best]) best = i;
        for (int i = 0; i < NUM_CLASS; i++)
          if (q[i] == q[best]) n++;
        e_cls = 2'(best);
        e_max = 3'(q[best]);
        e_tie = (n > 1);
        e_vld = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 5, 1'b1);
    cyc(1'b1, 6, 1'b1);
    vec++;
    if (obs !== 7'b0) begin
      errs++;
      $display("FAIL reset_state got=%b want=%b", obs, 7'b0);
    end
    // Reset coincident with the last count wins.
    cyc(1'b1, 1, 1'b0);
    cyc(1'b1, 2, 1'b0);
    cyc(1'b1, 7, 1'b1);
    vec++;
    if (obs !== 7'b0) begin
      errs++;
      $display("FAIL reset_on_last got=%b want=%b", obs, 7'b0);
    end
    cyc(1'b0, 0, 1'b0);
    vec++;
    if (obs !== 7'b0) begin
      errs++;
      $display("FAIL reset_on_last_after got=%b want=%b", obs, 7'b0);
    end
  endtask

  task automatic test_frames();
    cyc(1'b1, 2, 1'b0); cyc(1'b1, 5, 1'b0); cyc(1'b1, 3, 1'b0);
    vec++;
    if (obs !== {1'b1, 2'd1, 3'd5, 1'b0}) begin
      errs++;
      $display("FAIL frame_253 got=%b want=%b", obs, {1'b1, 2'd1, 3'd5, 1'b0});
    end
    cyc(1'b0, 0, 1'b0);
    vec++;
    if (obs !== {1'b0, 2'd1, 3'd5, 1'b0}) begin
      errs++;
      $display("FAIL hold_253 got=%b want=%b", obs, {1'b0, 2'd1, 3'd5, 1'b0});
    end
    cyc(1'b1, 4, 1'b0); cyc(1'b1, 4, 1'b0); cyc(1'b1, 1, 1'b0);
    vec++;
    if (obs !== {1'b1, 2'd0, 3'd4, 1'b1}) begin
      errs++;
      $display("FAIL frame_441 got=%b want=%b", obs, {1'b1, 2'd0, 3'd4, 1'b1});
    end
    cyc(1'b1, 3, 1'b0); cyc(1'b1, 3, 1'b0); cyc(1'b1, 6, 1'b0);
    vec++;
    if (obs !== {1'b1, 2'd2, 3'd6, 1'b0}) begin
      errs++;
      $display("FAIL frame_336 got=%b want=%b", obs, {1'b1, 2'd2, 3'd6, 1'b0});
    end
  endtask

  task automatic test_gaps();
    cyc(1'b1, 7, 1'b0);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    vec++;
    if (obs[6] !== 1'b0) begin
      errs++;
      $display("FAIL gap_early_vld got=%b want=0", obs[6]);
    end
    cyc(1'b1, 0, 1'b0);
    vec++;
    if (obs !== {1'b1, 2'd0, 3'd7, 1'b0}) begin
      errs++;
      $display("FAIL frame_gaps got=%b want=%b", obs, {1'b1, 2'd0, 3'd7, 1'b0});
    end
    cyc(1'b0, 0, 1'b0);
    vec++;
    if (obs !== {1'b0, 2'd0, 3'd7, 1'b0}) begin
      errs++;
      $display("FAIL gap_pulse_len got=%b want=%b", obs, {1'b0, 2'd0, 3'd7, 1'b0});
    end
    cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0);
    vec++;
    if (obs !== {1'b1, 2'd0, 3'd0, 1'b1}) begin
      errs++;
      $display("FAIL frame_000 got=%b want=%b", obs, {1'b1, 2'd0, 3'd0, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    int cnts[6] = '{1, 6, 2, 5, 5, 7};
    logic [6:0] want[6];
    want = '{{1'b0, 2'd0, 3'd0, 1'b1}, {1'b0, 2'd0, 3'd0, 1'b1},
             {1'b1, 2'd1, 3'd6, 1'b0}, {1'b0, 2'd1, 3'd6, 1'b0},
             {1'b0, 2'd1, 3'd6, 1'b0}, {1'b1, 2'd2, 3'd7, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, cnts[i], 1'b0);
      vec++;
      if (obs !== want[i]) begin
        errs++;
        $display("FAIL b2b_%0d got=%b want=%b", i, obs, want[i]);
      end
    end
    cyc(1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 6, 1'b0);
    cyc(1'b1, 2, 1'b0);
    cyc(1'b0, 0, 1'b1);
    vec++;
    if (obs !== 7'b0) begin
      errs++;
      $display("FAIL mid_reset_zero got=%b want=%b", obs, 7'b0);
    end
    cyc(1'b1, 1, 1'b0);
    vec++;
    if (obs[6] !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_stale_vld got=%b want=0", obs[6]);
    end
    cyc(1'b1, 2, 1'b0);
    vec++;
    if (obs[6] !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_early_vld got=%b want=0", obs[6]);
    end
    cyc(1'b1, 3, 1'b0);
    vec++;
    if (obs !== {1'b1, 2'd2, 3'd3, 1'b0}) begin
      errs++;
      $display("FAIL mid_reset_frame got=%b want=%b", obs, {1'b1, 2'd2, 3'd3, 1'b0});
    end
  endtask

  task automatic test_random();
    logic v;
    logic r;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 59) == 0);
      cyc(v, int'($urandom_range(0, 7)), r);
      vec++;
      if (obs !== {e_vld, e_cls, e_max, e_tie}) begin
        errs++;
        $display("FAIL random_%0d got=%b want=%b", i, obs, {e_vld, e_cls, e_max, e_tie});
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    b.cnt_vld = 1'b0;
    b.cnt_in  = '0;
    e_vld     = 1'b0;
    e_cls     = '0;
    e_max     = '0;
    e_tie     = 1'b0;
    test_reset();
    test_frames();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/vote_argmax.md
# vote_argmax

Sequential arg-max stage that sits directly downstream of the per-class vote popcount. It takes one vote count per valid cycle, in class order 0..NUM_CLASS-1, and tracks the running maximum. After the last class of a frame it emits the winning class index, its vote count and a tie flag. Its output is the final classification result of the random-forest inference path.

## Interface
- NUM_CLASS, 3: classes per frame, ≥2.
- COUNT_BIT, 3: width of each incoming vote count; matches the upstream popcount width.
- CLASS_BIT, $clog2(NUM_CLASS): width of the class index.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cnt_in  in  COUNT_BIT  vote count for the current class, unsigned.
- cnt_vld  in  1  cnt_in valid this cycle.
- class_out  out  CLASS_BIT  winning class index.
- max_out  out  COUNT_BIT  vote count of the winning class.
- tie_out  out  1  another class in the frame holds the same maximum count.
- out_vld  out  1  one-cycle pulse; class_out, max_out and tie_out are valid.

## Operation
- Internal class index counter idx (CLASS_BIT): reset to 0.
  - Advances by 1 on each cnt_vld.
  - Wraps from NUM_CLASS-1 to 0.
  - Holds when cnt_vld=0, so gaps between counts are allowed.
- Running registers: cur_max (COUNT_BIT), cur_cls (CLASS_BIT), cur_tie (1).
- On cnt_vld with idx==0 (frame start): cur_max←cnt_in, cur_cls←0, cur_tie←0. Prior state is discarded.
- On cnt_vld with idx>0:
  - cnt_in > cur_max: cur_max←cnt_in, cur_cls←idx, cur_tie←0.
  - cnt_in == cur_max: cur_tie←1; cur_max and cur_cls unchanged.
  - cnt_in < cur_max: no change.
- Tie policy: the lowest index among equal maxima wins.
- Comparison is unsigned, full COUNT_BIT width. No saturation or overflow is possible, since counts are only compared.
- Frame completion (cnt_vld with idx==NUM_CLASS-1):
  - The result includes this last sample, via the same compare logic applied combinationally.
  - The result is registered into class_out, max_out and tie_out.
  - out_vld=1 on the following cycle.
- Outputs hold their last frame result until the next frame completes. Only out_vld pulses.
- No backpressure: the consumer must accept on any out_vld cycle.

## Timing
- Reset values: class_out=0, max_out=0, tie_out=0, out_vld=0, idx=0, cur_max=0, cur_cls=0, cur_tie=0.
- Latency: out_vld rises exactly 1 cycle after the cycle carrying the frame's last cnt_vld.
- Throughput: one count per cycle. Frames may run back-to-back.
  - The cycle in which out_vld is high may carry the next frame's class-0 count.
  - That count must not disturb the registered outputs.
- Reset mid-frame: the partial frame is discarded and idx returns to 0. No out_vld is produced for that frame.
- Reset coincident with a last-class cnt_vld: reset wins; out_vld stays 0 next cycle.
- cnt_vld during reset is ignored.
- For a frame whose last count arrives in cycle T, out_vld is high in cycle T+1 only, regardless of gap cycles inside the frame.

## Test plan
- Counts 2,5,3 on consecutive cycles -> one cycle later: out_vld=1, class_out=1, max_out=5, tie_out=0.
- Counts 4,4,1 -> class_out=0, max_out=4, tie_out=1 (lowest index wins).
- Counts 3,3,6 -> class_out=2, max_out=6, tie_out=0 (tie cleared by a larger later value).
- Counts 7, two idle cycles, 0, one idle cycle, 0 -> single out_vld 1 cycle after the third count, class_out=0, max_out=7, tie_out=0; all-zero frame 0,0,0 -> class_out=0, max_out=0, tie_out=1.
- Back-to-back frames 1,6,2 then 5,5,7 with no gaps -> out_vld at cycles 3 and 6. Results: (1,6,0), then (2,7,0). Outputs hold (1,6,0) between the pulses.
- Counts 6,2, then rst high 1 cycle, then 1,2,3 -> exactly one out_vld, with class_out=2, max_out=3, tie_out=0. All outputs read 0 right after reset.
